// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide) owning HI/LO.
// Optional MUL_DIV_FAST_MUL_EN: single-cycle MULT/MULTU via a combinational 64-bit multiply.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       aluFunct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               neg_q, neg_d, negr_q, negr_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               res_valid_q, res_valid_d, done_q, done_d;

  logic               accept, is_signed, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] fix;
`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      p_q         <= '0;
      d_q         <= '0;
      neg_q       <= 1'b0;
      negr_q      <= 1'b0;
      dz_q        <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      p_q         <= p_d;
      d_q         <= d_d;
      neg_q       <= neg_d;
      negr_q      <= negr_d;
      dz_q        <= dz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    d_d         = d_q;
    neg_d       = neg_q;
    negr_d      = negr_q;
    dz_d        = dz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    sum         = '0;
    trial       = '0;
    fix         = '0;
    accept      = in_valid && (state_q == S_IDLE) && !flush;
    is_signed   = (aluFunct == FUN_MULT) || (aluFunct == FUN_DIV);
    a_mag       = (is_signed && opA[WIDTH-1]) ? -opA : opA;
    b_mag       = (is_signed && opB[WIDTH-1]) ? -opB : opB;
    last        = (count_q == CNT_W'(WIDTH-1));
`ifdef MUL_DIV_FAST_MUL_EN
    ext_a       = is_signed ? {{WIDTH{opA[WIDTH-1]}}, opA} : {{WIDTH{1'b0}}, opA};
    ext_b       = is_signed ? {{WIDTH{opB[WIDTH-1]}}, opB} : {{WIDTH{1'b0}}, opB};
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (aluFunct)
            FUN_MFHI: begin result_d = hi_q; res_valid_d = 1'b1; end
            FUN_MFLO: begin result_d = lo_q; res_valid_d = 1'b1; end
            FUN_MTHI: hi_d = opA;
            FUN_MTLO: lo_d = opA;
            FUN_MULT, FUN_MULTU: begin
`ifdef MUL_DIV_FAST_MUL_EN
              {hi_d, lo_d} = ext_a * ext_b;
              done_d       = 1'b1;
`else
              state_d = S_MUL;
              count_d = '0;
              d_d     = a_mag;
              p_d     = {{WIDTH{1'b0}}, b_mag};
              neg_d   = is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
              negr_d  = 1'b0;
              dz_d    = 1'b0;
`endif
            end
            FUN_DIV, FUN_DIVU: begin
              state_d = S_DIV;
              count_d = '0;
              d_d     = b_mag;
              p_d     = {{WIDTH{1'b0}}, a_mag};
              neg_d   = is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
              negr_d  = is_signed && opA[WIDTH-1];
              dz_d    = (opB == '0);
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // upper half accumulates, whole product/multiplier pair shifts right
          sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
          p_d     = {sum, p_q[WIDTH-1:1]};
          count_d = count_q + CNT_W'(1);
          if (last) begin
            fix          = neg_q ? -p_d : p_d;
            {hi_d, lo_d} = fix;
            state_d      = S_IDLE;
            done_d       = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, d_q};
          if (!trial[WIDTH]) p_d = {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          else               p_d = {p_q[2*WIDTH-2:0], 1'b0};
          count_d = count_q + CNT_W'(1);
          if (last) begin
            // divide-by-zero keeps the all-ones quotient; remainder sign restores opA
            lo_d    = (neg_q && !dz_q) ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
            hi_d    = negr_q ? -p_d[2*WIDTH-1:WIDTH] : p_d[2*WIDTH-1:WIDTH];
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n && (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    res_valid = res_valid_q;
    done      = done_q;
    result    = result_q;
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expectations, a negedge monitor pops them.
module tb_mul_div_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif

  logic        clk = 1'b0;
  logic        reset_n, in_valid, flush, in_ready, res_valid, done, busy;
  logic [5:0]  aluFunct;
  logic [31:0] opA, opB, result, hi, lo;

  typedef struct {
    bit          is_res;
    logic [31:0] r;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluFunct(aluFunct), .opA(opA), .opB(opB), .flush(flush),
    .res_valid(res_valid), .result(result), .done(done), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every result/done strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset_n && (res_valid || done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got res_valid=%b done=%b expected none", res_valid, done);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_res) begin
          check("res_valid_strobe", {31'b0, res_valid}, 32'd1);
          check("result", result, e.r);
        end else begin
          check("done_strobe", {31'b0, done}, 32'd1);
          check("hi", hi, e.h);
          check("lo", lo, e.l);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b1; aluFunct = f; opA = a; opB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, exp_cyc);
  endtask

  task automatic long_op(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
    exp_t e;
    e.is_res = 1'b0; e.r = '0; e.h = eh; e.l = el;
    q.push_back(e);
    mhi = eh; mlo = el;
    issue(f, a, b);
    check({name, "_ready_after_e0"}, {31'b0, in_ready}, (cyc == 0) ? 32'd1 : 32'd0);
    wait_idle({name, "_cycles"}, cyc);
  endtask

  task automatic mf(input logic [5:0] f, input logic [31:0] exp);
    exp_t e;
    e.is_res = 1'b1; e.r = exp; e.h = '0; e.l = '0;
    q.push_back(e);
    issue(f, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; aluFunct = '0; opA = '0; opB = '0;
    #2;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_result", result, '0);
    check("rst_flags", {28'b0, res_valid, done, busy, 1'b0}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    issue(F_MTHI, 32'h1234_5678, '0);
    mhi = 32'h1234_5678;
    check("mthi_hi", hi, 32'h1234_5678);
    mf(F_MFHI, 32'h1234_5678);

    long_op("mult_neg", F_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_CYC);
    long_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC);
    long_op("div_neg",  F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    long_op("divu_z",   F_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 32);
    long_op("div_z",    F_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 32);
    long_op("div_ovf",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 32);
    mf(F_MFLO, 32'h8000_0000);

    // flush while dividing: HI/LO keep the overflow result
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hi", hi, mhi);
    check("flush_lo", lo, mlo);
    repeat (3) begin @(posedge clk); #1; end

    long_op("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32);

    issue(F_ADD, 32'hCAFE_F00D, 32'd1);
    check("nop_ready", {31'b0, in_ready}, 32'd1);
    check("nop_lo", lo, mlo);

    // flush in IDLE suppresses MTLO and MFHI
    in_valid = 1'b1; flush = 1'b1; aluFunct = F_MTLO; opA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    aluFunct = F_MFHI;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_lo", lo, mlo);
    mf(F_MFLO, 32'd14);

    // reset mid-operation
`ifdef MUL_DIV_FAST_MUL_EN
    issue(F_DIVU, 32'd5, 32'd7);
`else
    issue(F_MULT, 32'd5, 32'd7);
`endif
    repeat (4) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    mhi = '0; mlo = '0;
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    check("arst_result", result, '0);
    check("arst_flags", {27'b0, in_ready, res_valid, done, busy, 1'b0}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("arst_ready_release", {31'b0, in_ready}, 32'd1);
    mf(F_MFLO, 32'd0);

    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit; sits directly downstream of the ALU function decoder and consumes its 6-bit aluFunct code alongside the two operands.
- Handles the HI/LO class of functs: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Owns the architectural HI/LO registers.
- Multiply and divide are iterative; the pipeline stalls on in_ready while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present this cycle
- in_ready  output  1  unit can accept a request (high only in IDLE)
- aluFunct  input  6  funct code from the decoder, `FUN_* encoding from ISA.v
- opA  input  WIDTH  rs value (dividend / multiplicand / MTxx source)
- opB  input  WIDTH  rt value (divisor / multiplier)
- flush  input  1  abort the in-flight op (branch/exception squash)
- res_valid  output  1  one-cycle pulse: result is valid (MFHI/MFLO)
- result  output  WIDTH  MFHI/MFLO data, registered
- done  output  1  one-cycle pulse: MULT/DIV family has committed HI/LO
- busy  output  1  high in MUL or DIV state
- hi, lo  output  WIDTH  current HI/LO (debug/trace)

Behaviour:
- Reset (reset_n low, async): state IDLE; hi, lo, result, count at 0; res_valid, done, busy at 0; in_ready at 1 once reset is released.
- Accept rule: handshake occurs at a rising edge with in_valid && in_ready. Accepting a funct outside the HI/LO class is a no-op: no state change, no pulses.
- States:
  - IDLE
  - MUL: 32 iterations, shift-add on magnitudes.
  - DIV: 32 iterations, restoring radix-2 on magnitudes.
- MFHI/MFLO, accepted at edge E0: result = hi/lo, res_valid = 1 during the cycle after E0. Stays in IDLE, back-to-back capable.
- MTHI/MTLO, accepted at E0: hi/lo = opA at E0. No pulse.
- MULT/MULTU/DIV/DIVU, accepted at E0:
  - Operands captured at E0; signed variants convert to magnitude and record signs.
  - State becomes MUL/DIV; count = 0; in_ready = 0 and busy = 1 from E0.
  - One iteration per edge E1..E32.
  - At E32: sign fix-up applied and {hi,lo} written; state returns to IDLE; done = 1 during the cycle after E32.
  - Total issue-to-next-accept: 33 cycles.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient is negative iff the operand signs differ; remainder takes the sign of opA.
- Divide by zero (opB == 0, either variant): lo = 0xFFFFFFFF, hi = opA. Still takes 32 iterations, no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude path; it must not be special-cased incorrectly.
- flush:
  - In MUL/DIV: state goes to IDLE at that edge; hi/lo are unchanged; no done pulse.
  - In IDLE: a same-edge accept is suppressed (flush wins).
  - Suppresses a pending res_valid pulse scheduled for the next cycle.
- hi, lo, and result change only on the events listed above.
- reset_n asserted mid-operation: immediate return to reset values; partial results are discarded.

Optional Feature:
- Macro: MUL_DIV_FAST_MUL_EN.
- Defined: MULT/MULTU complete single-cycle. {hi,lo} is written at the accepting edge E0 using a combinational signed/unsigned 64-bit multiply; done pulses the cycle after E0; in_ready never drops for multiply. DIV is unchanged.
- Undefined: iterative 32-cycle multiply as specified above.

Test Plan:
- MTHI 0x12345678, then MFHI -> res_valid one cycle after the MFHI accept, result = 0x12345678.
- MULT opA = 0xFFFFFFFE (-2), opB = 3 -> in_ready low for E0..E32 (iterative build); then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; done single pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU 7 / 0 -> lo = 0xFFFFFFFF, hi = 7. DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- DIVU 100 / 7 with flush at iteration 10 -> no done pulse; hi/lo keep prior values; in_ready high the next cycle.
- reset_n low at iteration 5 of MULT -> all outputs 0 immediately (async). After release: in_ready = 1 and MFLO returns 0.
